v_query_rsp_q: RTL and testbench
================================

V_QUERY_RSP_Q -- requirements
Module: v_query_rsp_q

Interface
REQ-001 Parameter DEPTH, default 4, response-queue entries; legal values are powers of two, 2..16.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_lut_vld  in  1  query issued to query pipe this cycle (S0).
REQ-005 o_lut_ready  out  1  issuer may assert i_lut_vld this cycle.
REQ-006 i_lut_vld_r  in  1  query pipe S1 result valid.
REQ-007 i_lut_key, i_lut_size, i_lut_error, i_lut_listsize  in  v_pkg::key_t / volume_t / 1 / listsize_t  S1 result fields.
REQ-008 o_rsp_vld  out  1  head response valid.
REQ-009 o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize  out  as REQ-007  head response fields.
REQ-010 i_rsp_accept  in  1  consumer takes head this cycle; ignored when o_rsp_vld=0.
REQ-011 o_overflow_r  out  1  sticky protocol-violation flag.

Function
REQ-012 Block SHALL buffer query-pipe results, since that pipe cannot stall.
REQ-013 Credit counter cred_cnt (0..DEPTH) SHALL count queued entries plus in-flight queries.
- +1 on i_lut_vld & o_lut_ready.
- -1 on pop (o_rsp_vld & i_rsp_accept).
- Unchanged on simultaneous issue and pop.
REQ-014 o_lut_ready SHALL equal (cred_cnt < DEPTH), combinational from flops only, with no dependence on i_rsp_accept.
REQ-015 i_lut_vld while o_lut_ready=0 SHALL NOT change cred_cnt, SHALL set o_overflow_r, and the matching result SHALL be dropped at the write port.
REQ-016 Query-pipe latency is one cycle: i_lut_vld at cycle t yields i_lut_vld_r at t+1.
- Block SHALL track a 1-bit drop flag for result t+1 so that only results of credited issues are written.
REQ-017 A credited i_lut_vld_r SHALL be written at the tail that cycle.
REQ-018 A written entry SHALL be visible on o_rsp_* from the next cycle; no same-cycle bypass.
REQ-019 Write and pop in the same cycle SHALL both occur, including when queue is full, empty, or has one entry.
REQ-020 Queue order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-021 o_rsp_* SHALL be held stable while o_rsp_vld=1 and i_rsp_accept=0.
REQ-022 Credited i_lut_vld_r when queue occupancy equals DEPTH is impossible by construction and SHALL be covered by an assertion.
REQ-023 i_lut_vld_r with no issue at t-1 SHALL set o_overflow_r and SHALL NOT be written.
REQ-024 o_overflow_r SHALL clear only on reset.

Reset
REQ-025 On arst_n low, all of the following SHALL take effect asynchronously:
- cred_cnt=0, pointers=0, occupancy=0, drop flag=0.
- o_rsp_vld=0, o_overflow_r=0, o_lut_ready=1 (once cred_cnt=0).
REQ-026 Queue payload storage SHALL NOT require reset; o_rsp_* data is don't-care while o_rsp_vld=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight responses.
- A result arriving on the first cycle after deassertion SHALL be dropped and SHALL set o_overflow_r.

Structure
REQ-028 v_pkg SHALL gain typedef rsp_t, a packed struct {key_t key; volume_t volume; logic error; listsize_t listsize}.
REQ-029 v_pkg SHALL gain the constant RSP_Q_DEPTH_DEFAULT=4.
REQ-030 Storage SHALL be one sub-module v_rsp_fifo, parameterised by width and depth, with push/pop/full/empty and registered head.
- Credit and drop logic SHALL remain in v_query_rsp_q.

Verification
REQ-031 Single query: i_lut_vld at t=0, key=0x5A, result at t=1.
- o_rsp_vld=1 at t=2 with key 0x5A.
- cred_cnt returns to 0 after accept at t=2.
REQ-032 Fill with i_rsp_accept=0 and DEPTH=4: issue on 4 consecutive cycles.
- o_lut_ready=0 from cycle 4.
- 4 entries returned in order once accept is raised.
REQ-033 Full queue with simultaneous pop and issue: cred_cnt stays at 4, o_lut_ready stays 0, order preserved.
REQ-034 Issue while o_lut_ready=0: o_overflow_r=1 next cycle, queue contents unchanged, no fifth entry appears.
REQ-035 Reset mid-stream: 3 entries queued, arst_n low for 2 cycles.
- o_rsp_vld=0 immediately.
- o_lut_ready=1 after deassert, o_overflow_r=0.
REQ-036 Error passthrough: result with error=1, listsize=3 is delivered unchanged, with no effect on credit.

Source files
------------

// File: rtl/v_pkg.sv
// Shared types for the query/response path: key, volume and list-size fields
// plus the packed response record carried by the response queue.
package v_pkg;

  typedef logic [15:0] key_t;
  typedef logic [15:0] volume_t;
  typedef logic [3:0]  listsize_t;

  typedef struct packed {
    key_t      key;
    volume_t   volume;
    logic      error;
    listsize_t listsize;
  } rsp_t;

  localparam int unsigned RSP_Q_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/v_rsp_fifo.sv
// Generic FIFO with the head read straight from registered storage.
// A push and a pop may share a cycle at any occupancy, including full.
module v_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot at the same edge, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: payload storage has no reset; entries are only observed once the
  // counter marks them valid, so resetting them would only cost flop area.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so plain increments wrap modulo DEPTH.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!arst_n) !(push && full && !pop)
  );

endmodule

// File: rtl/v_query_rsp_q.sv
// Credit-controlled response queue behind a non-stallable one-cycle query pipe;
// only results of credited issues are stored, anything else flags overflow.
module v_query_rsp_q
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = RSP_Q_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      i_lut_vld,
  output logic      o_lut_ready,
  input  logic      i_lut_vld_r,
  input  key_t      i_lut_key,
  input  volume_t   i_lut_size,
  input  logic      i_lut_error,
  input  listsize_t i_lut_listsize,
  output logic      o_rsp_vld,
  output key_t      o_rsp_key,
  output volume_t   o_rsp_size,
  output logic      o_rsp_error,
  output listsize_t o_rsp_listsize,
  input  logic      i_rsp_accept,
  output logic      o_overflow_r
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cred_cnt;
  logic             lut_pend_r;
  logic             issue;
  logic             pop;
  logic             rsp_wr;
  logic             fifo_full;
  logic             fifo_empty;
  rsp_t             wr_rsp;
  rsp_t             head_rsp;

  // Ready comes from the credit flop alone so the issuer never sees a path
  // from the consumer's accept.
  assign o_lut_ready = (cred_cnt < CNT_W'(DEPTH));
  assign issue       = i_lut_vld & o_lut_ready;
  assign pop         = o_rsp_vld & i_rsp_accept;
  assign rsp_wr      = i_lut_vld_r & lut_pend_r;
  assign o_rsp_vld   = ~fifo_empty;

  assign wr_rsp = '{key: i_lut_key, volume: i_lut_size,
                    error: i_lut_error, listsize: i_lut_listsize};

  assign o_rsp_key      = head_rsp.key;
  assign o_rsp_size     = head_rsp.volume;
  assign o_rsp_error    = head_rsp.error;
  assign o_rsp_listsize = head_rsp.listsize;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cred_cnt     <= '0;
      lut_pend_r   <= 1'b0;
      o_overflow_r <= 1'b0;
    end else begin
      case ({issue, pop})
        2'b10:   cred_cnt <= cred_cnt + CNT_W'(1);
        2'b01:   cred_cnt <= cred_cnt - CNT_W'(1);
        default: cred_cnt <= cred_cnt;
      endcase
      // Marks whether next cycle's pipe result belongs to a credited issue;
      // clearing it on reset drops any result still in the pipe.
      lut_pend_r   <= issue;
      o_overflow_r <= o_overflow_r
                    | (i_lut_vld & ~o_lut_ready)
                    | (i_lut_vld_r & ~lut_pend_r);
    end
  end

  v_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (rsp_wr),
    .push_data (wr_rsp),
    .pop       (pop),
    .head      (head_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credits cap queued plus in-flight entries at DEPTH, so a credited result
  // can never meet a full queue.
  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (!arst_n) !(rsp_wr && fifo_full)
  );

endmodule

// File: tb/tb_v_query_rsp_q.sv
// Directed bench for v_query_rsp_q: stimulus pushes expected responses into a
// scoreboard queue; a monitor pops and compares on every accepted head.
module tb_v_query_rsp_q;
  import v_pkg::*;

  logic      clk = 1'b0;
  logic      arst_n;
  logic      i_lut_vld;
  logic      o_lut_ready;
  logic      i_lut_vld_r;
  key_t      i_lut_key;
  volume_t   i_lut_size;
  logic      i_lut_error;
  listsize_t i_lut_listsize;
  logic      o_rsp_vld;
  key_t      o_rsp_key;
  volume_t   o_rsp_size;
  logic      o_rsp_error;
  listsize_t o_rsp_listsize;
  logic      i_rsp_accept;
  logic      o_overflow_r;

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  logic prev_vld;
  rsp_t prev_rsp;

  v_query_rsp_q #(.DEPTH(4)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_lut_vld      (i_lut_vld),
    .o_lut_ready    (o_lut_ready),
    .i_lut_vld_r    (i_lut_vld_r),
    .i_lut_key      (i_lut_key),
    .i_lut_size     (i_lut_size),
    .i_lut_error    (i_lut_error),
    .i_lut_listsize (i_lut_listsize),
    .o_rsp_vld      (o_rsp_vld),
    .o_rsp_key      (o_rsp_key),
    .o_rsp_size     (o_rsp_size),
    .o_rsp_error    (o_rsp_error),
    .o_rsp_listsize (o_rsp_listsize),
    .i_rsp_accept   (i_rsp_accept),
    .o_overflow_r   (o_overflow_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input key_t k);
    rsp_t r;
    r.key      = k;
    r.volume   = k + 16'h0100;
    r.error    = 1'b0;
    r.listsize = k[3:0];
    return r;
  endfunction

  // One cycle: the query pipe returns last cycle's issue, a new issue is driven,
  // and the hand-computed ready value is checked before the edge.
  task automatic step(input logic vld, input rsp_t r, input logic acc, input logic exp_ready);
    i_lut_vld_r = prev_vld;
    {i_lut_key, i_lut_size, i_lut_error, i_lut_listsize} = prev_rsp;
    i_lut_vld    = vld;
    i_rsp_accept = acc;
    @(negedge clk);
    check("lut_ready", {63'd0, o_lut_ready}, {63'd0, exp_ready});
    if (vld && exp_ready) exp_q.push_back(r);
    prev_vld = vld;
    prev_rsp = r;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, plus a stability check on a stalled head.
  rsp_t held;
  logic hold_v = 1'b0;
  always @(negedge clk) begin
    rsp_t cur;
    rsp_t exp;
    cur = '{key: o_rsp_key, volume: o_rsp_size, error: o_rsp_error, listsize: o_rsp_listsize};
    if (!arst_n) begin
      hold_v = 1'b0;
    end else if (o_rsp_vld) begin
      if (hold_v) check("head_stable", 64'(cur), 64'(held));
      if (i_rsp_accept) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_pop: got %h with no response expected", cur);
        end else begin
          exp = exp_q.pop_front();
          check("sb_rsp", 64'(cur), 64'(exp));
        end
      end else begin
        hold_v = 1'b1;
        held   = cur;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    rsp_t e;
    arst_n = 1'b0;
    i_lut_vld = 1'b0; i_lut_vld_r = 1'b0; i_rsp_accept = 1'b0;
    i_lut_key = '0; i_lut_size = '0; i_lut_error = 1'b0; i_lut_listsize = '0;
    prev_vld = 1'b0;
    prev_rsp = '0;
    #2;
    check("rst_rsp_vld",  {63'd0, o_rsp_vld},    64'd0);
    check("rst_ready",    {63'd0, o_lut_ready},  64'd1);
    check("rst_overflow", {63'd0, o_overflow_r}, 64'd0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // Single query: result one cycle later, visible the cycle after that.
    step(1'b1, mk(16'h005A), 1'b0, 1'b1);
    check("t1_no_bypass", {63'd0, o_rsp_vld}, 64'd0);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    check("t2_rsp_vld", {63'd0, o_rsp_vld}, 64'd1);
    check("t2_rsp_key", 64'(o_rsp_key), 64'h5A);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    check("t3_empty", {63'd0, o_rsp_vld}, 64'd0);
    check("t3_no_overflow", {63'd0, o_overflow_r}, 64'd0);

    // Fill four credits with no accept.
    step(1'b1, mk(16'h0011), 1'b0, 1'b1);
    step(1'b1, mk(16'h0012), 1'b0, 1'b1);
    step(1'b1, mk(16'h0013), 1'b0, 1'b1);
    step(1'b1, mk(16'h0014), 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b0);
    check("full_head", 64'(o_rsp_key), 64'h11);

    // Issue while not ready: overflow, and its result must not be queued.
    step(1'b1, mk(16'h00EE), 1'b0, 1'b0);
    step(1'b0, mk(16'h0000), 1'b0, 1'b0);
    check("ovf_set", {63'd0, o_overflow_r}, 64'd1);
    check("ovf_head", 64'(o_rsp_key), 64'h11);

    // Pop at full: ready stays low that cycle, then issue and pop together.
    step(1'b1, mk(16'h0015), 1'b1, 1'b0);
    step(1'b1, mk(16'h0016), 1'b1, 1'b1);
    step(1'b1, mk(16'h0017), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    check("drain_empty", {63'd0, o_rsp_vld}, 64'd0);

    // Write and pop in the same cycle on a one-entry queue.
    step(1'b1, mk(16'h0021), 1'b0, 1'b1);
    step(1'b1, mk(16'h0022), 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    check("one_entry_head", 64'(o_rsp_key), 64'h22);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);

    // Error passthrough.
    e = '{key: 16'h0033, volume: 16'h1234, error: 1'b1, listsize: 4'd3};
    step(1'b1, e, 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    check("err_flag", {63'd0, o_rsp_error}, 64'd1);
    check("err_listsize", 64'(o_rsp_listsize), 64'd3);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);

    // Reset mid-stream with three entries queued.
    step(1'b1, mk(16'h0041), 1'b0, 1'b1);
    step(1'b1, mk(16'h0042), 1'b0, 1'b1);
    step(1'b1, mk(16'h0043), 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    check("pre_rst_vld", {63'd0, o_rsp_vld}, 64'd1);
    arst_n = 1'b0;
    i_lut_vld = 1'b0; i_lut_vld_r = 1'b0; i_rsp_accept = 1'b0;
    #1;
    check("mid_rst_vld",      {63'd0, o_rsp_vld},    64'd0);
    check("mid_rst_ready",    {63'd0, o_lut_ready},  64'd1);
    check("mid_rst_overflow", {63'd0, o_overflow_r}, 64'd0);
    exp_q.delete();
    prev_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;

    // A result on the first cycle after reset is stray.
    prev_vld = 1'b1;
    prev_rsp = mk(16'h0099);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    check("post_rst_ovf", {63'd0, o_overflow_r}, 64'd1);
    check("post_rst_vld", {63'd0, o_rsp_vld},    64'd0);

    step(1'b1, mk(16'h0051), 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);
    step(1'b0, mk(16'h0000), 1'b1, 1'b1);
    step(1'b0, mk(16'h0000), 1'b0, 1'b1);

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
